// File: rtl/rip_bram_lsu.sv
// rip_bram_lsu: load/store front end for port 1 of the byte-write data BRAM, splitting word-crossing accesses
module rip_bram_lsu #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  bram_enable,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_din,
  input  logic [31:0]           bram_dout,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;
  logic [0:0] state;
  logic [1:0] off;
  logic [ADDR_WIDTH-1:0] word;
  logic [3:0] szm;
  logic [7:0] mask;
  logic err, split, acc, go;
  logic [31:0] rot;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [3:0] s_we;
  logic [31:0] s_din;
  logic s1_v, s1_ld, s1_sp, s1_err, s2_v, s2_ld;
  logic [2:0] s1_f3, s2_f3;
  logic [1:0] s1_off, s2_off;
  logic [31:0] hold;
  logic fin, c_ld, c_err;
  logic [2:0] c_f3;
  logic [1:0] c_off;
  logic [31:0] lo, w, ext;
  logic [23:0] hi;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  // Decode the incoming request and drive the BRAM port from it, or from the latched second half
  always_comb begin
    off = req_addr[1:0];
    word = req_addr[ADDR_WIDTH+1:2];
    err = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]);
    szm = req_funct3[1:0] == 2'b00 ? 4'b0001 : req_funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    mask = {4'b0000, szm} << off;
    split = !err && |mask[7:4];
    acc = req_valid && state == IDLE;
    go = acc && !err;
    rot = off == 2'd0 ? req_wdata : off == 2'd1 ? {req_wdata[23:0], req_wdata[31:24]} :
          off == 2'd2 ? {req_wdata[15:0], req_wdata[31:16]} : {req_wdata[7:0], req_wdata[31:8]};
    req_ready = state == IDLE;
    bram_enable = state == SPLIT || go;
    bram_addr = state == SPLIT ? s_addr : word;
    bram_we = state == SPLIT ? s_we : (go && req_we) ? mask[3:0] : 4'b0000;
    bram_din = state == SPLIT ? s_din : rot;
  end
  // FSM plus the second-access registers captured when a request is accepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      s_addr <= '0;
      s_we <= '0;
      s_din <= '0;
    end else begin
      state <= (acc && split) ? SPLIT : IDLE;
      if (acc) begin
        s_addr <= word + ADDR_WIDTH'(1);
        s_we <= req_we ? mask[7:4] : 4'b0000;
        s_din <= rot;
      end
    end
  // Pick the finishing request (split from stage 2, otherwise stage 1) and extract its load data
  always_comb begin
    fin = s2_v || (s1_v && !s1_sp);
    c_ld = s2_v ? s2_ld : s1_ld;
    c_f3 = s2_v ? s2_f3 : s1_f3;
    c_off = s2_v ? s2_off : s1_off;
    c_err = !s2_v && s1_err;
    lo = s2_v ? hold : bram_dout;
    hi = s2_v ? bram_dout[23:0] : 24'd0;
    w = c_off == 2'd0 ? lo : c_off == 2'd1 ? {hi[7:0], lo[31:8]} :
        c_off == 2'd2 ? {hi[15:0], lo[31:16]} : {hi[23:0], lo[31:24]};
    ext = c_f3[1:0] == 2'b00 ? {{24{~c_f3[2] & w[7]}}, w[7:0]} :
          c_f3[1:0] == 2'b01 ? {{16{~c_f3[2] & w[15]}}, w[15:0]} : w;
  end
  // Response pipeline: stage 1 follows every access, stage 2 only the second half of a split
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_ld <= 1'b0;
      s1_sp <= 1'b0;
      s1_err <= 1'b0;
      s1_f3 <= '0;
      s1_off <= '0;
      s2_v <= 1'b0;
      s2_ld <= 1'b0;
      s2_f3 <= '0;
      s2_off <= '0;
      hold <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      s1_v <= acc;
      s1_ld <= !req_we;
      s1_sp <= split;
      s1_err <= err;
      s1_f3 <= req_funct3;
      s1_off <= off;
      s2_v <= s1_v && s1_sp;
      s2_ld <= s1_ld;
      s2_f3 <= s1_f3;
      s2_off <= s1_off;
      if (s1_v && s1_sp) hold <= bram_dout;
      rsp_valid <= fin;
      rsp_err <= fin && c_err;
      rsp_rdata <= (fin && c_ld && !c_err) ? ext : 32'd0;
    end
endmodule

// File: tb/tb_rip_bram_lsu.sv
// tb_rip_bram_lsu: randomized and directed checks of rip_bram_lsu against a byte-level memory model
module tb_rip_bram_lsu;
  localparam int AW = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic bram_enable;
  logic [AW-1:0] bram_addr;
  logic [3:0] bram_we;
  logic [31:0] bram_din, bram_dout;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem [1024];
  logic [7:0] mb [4096];
  logic clr_mem = 1'b0;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct {int due; logic [31:0] rd; logic err;} exp_t;
  exp_t q[$];
  logic p2v = 1'b0, p2st = 1'b0;
  logic [AW-1:0] p2a = '0;
  logic [3:0] p2w = '0;
  logic [31:0] p2d = '0;
  logic [2:0] fl [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  rip_bram_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .bram_enable(bram_enable), .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
    .bram_dout(bram_dout), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // byte-write BRAM, read-first, one cycle read latency
  always @(posedge clk) begin
    if (clr_mem) for (int i = 0; i < 1024; i++) mem[i] <= '0;
    else if (bram_enable) begin
      for (int b = 0; b < 4; b++) if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      bram_dout <= mem[bram_addr];
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // reference model and per-cycle compare
  always @(negedge clk) begin : mon
    logic [1:0] o;
    logic [2:0] f;
    int sz, p;
    logic e;
    logic [3:0] w1, w2;
    logic [31:0] v, rd;
    logic [11:0] ba;
    exp_t x;
    if (clr_mem) for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    if (rst) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_bram_enable", 32'(bram_enable), 0);
      chk("rst_req_ready", 32'(req_ready), 1);
      q.delete();
      p2v = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
        else begin
          x = q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(x.due));
          chk("rsp_rdata", rsp_rdata, x.rd);
          chk("rsp_err", 32'(rsp_err), 32'(x.err));
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("rsp_missing", 32'(rsp_valid), 1);
        void'(q.pop_front());
      end
      chk("req_ready", 32'(req_ready), 32'(!p2v));
      if (p2v) begin
        chk("second_enable", 32'(bram_enable), 1);
        chk("second_addr", 32'(bram_addr), 32'(p2a));
        chk("second_we", 32'(bram_we), 32'(p2w));
        if (p2st) chk("second_din", bram_din, p2d);
        p2v = 1'b0;
      end else if (req_valid) begin
        o = req_addr[1:0];
        f = req_funct3;
        ba = req_addr[11:0];
        sz = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
        e = f == 3'b011 || f == 3'b110 || f == 3'b111 || (req_we && f[2]);
        w1 = '0;
        w2 = '0;
        for (int i = 0; i < sz; i++) begin
          p = int'(o) + i;
          if (p < 4) w1[p] = 1'b1; else w2[p-4] = 1'b1;
        end
        for (int b = 0; b < 4; b++) v[8*((b + int'(o)) % 4) +: 8] = req_wdata[8*b +: 8];
        rd = '0;
        if (!e && !req_we) begin
          for (int i = 0; i < sz; i++) rd[8*i +: 8] = mb[(int'(ba) + i) % 4096];
          if (!f[2]) rd = sz == 1 ? {{24{rd[7]}}, rd[7:0]} : sz == 2 ? {{16{rd[15]}}, rd[15:0]} : rd;
        end
        if (!e && req_we) for (int i = 0; i < sz; i++) mb[(int'(ba) + i) % 4096] = req_wdata[8*i +: 8];
        if (e) chk("err_enable", 32'(bram_enable), 0);
        else begin
          chk("first_enable", 32'(bram_enable), 1);
          chk("first_addr", 32'(bram_addr), 32'(ba[11:2]));
          chk("first_we", 32'(bram_we), req_we ? 32'(w1) : 0);
          if (req_we) chk("first_din", bram_din, v);
        end
        x.due = cyc + ((!e && w2 != 0) ? 3 : 2);
        x.rd = rd;
        x.err = e;
        q.push_back(x);
        if (!e && w2 != 0) begin
          p2v = 1'b1;
          p2a = ba[11:2] + 10'd1;
          p2w = req_we ? w2 : 4'b0000;
          p2d = v;
          p2st = req_we;
        end
      end else chk("idle_enable", 32'(bram_enable), 0);
    end
  end

  task automatic single(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic en, input logic [3:0] w1, input logic [31:0] din,
                        input logic [31:0] rd, input logic err, input int lat, input string nm);
    int n;
    bit got;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(negedge clk);
    n = cyc;
    chk({nm, "_enable"}, 32'(bram_enable), 32'(en));
    chk({nm, "_we"}, 32'(bram_we), 32'(w1));
    if (we && en) chk({nm, "_din"}, bram_din, din);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk({nm, "_rsp_seen"}, 32'(got), 1);
    if (got) begin
      chk({nm, "_latency"}, 32'(cyc - n), 32'(lat));
      chk({nm, "_rdata"}, rsp_rdata, rd);
      chk({nm, "_err"}, 32'(rsp_err), 32'(err));
    end
  endtask

  task automatic clear_mems();
    @(posedge clk);
    #1;
    clr_mem = 1'b1;
    @(posedge clk);
    #1;
    clr_mem = 1'b0;
  endtask

  initial begin
    int r, m;
    logic [31:0] a;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    clr_mem = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_mem = 1'b0;
    single(1'b1, 3'b010, 32'h8, 32'h11223344, 1'b1, 4'b1111, 32'h11223344, 32'h0, 1'b0, 2, "sw8");
    single(1'b0, 3'b010, 32'h8, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h11223344, 1'b0, 2, "lw8");
    single(1'b1, 3'b000, 32'h5, 32'h000000A5, 1'b1, 4'b0010, 32'h0000A500, 32'h0, 1'b0, 2, "sb5");
    single(1'b0, 3'b000, 32'h5, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFA5, 1'b0, 2, "lb5");
    single(1'b0, 3'b100, 32'h5, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h000000A5, 1'b0, 2, "lbu5");
    single(1'b1, 3'b010, 32'h7, 32'hDEADBEEF, 1'b1, 4'b1000, 32'hEFDEADBE, 32'h0, 1'b0, 3, "sw7");
    single(1'b0, 3'b010, 32'h7, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 3, "lw7");
    single(1'b0, 3'b101, 32'h7, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0000BEEF, 1'b0, 3, "lhu7");
    single(1'b1, 3'b001, 32'hFFF, 32'h00008001, 1'b1, 4'b1000, 32'h01000080, 32'h0, 1'b0, 3, "sh_top");
    single(1'b0, 3'b001, 32'hFFF, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 3, "lh_top");
    single(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2, "err_ld");
    single(1'b1, 3'b110, 32'h10, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2, "err_st");
    single(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0, 2, "lw10");
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      req_valid = ($urandom % 4) != 0;
      req_we = 1'($urandom);
      r = int'($urandom % 16);
      req_funct3 = r < 14 ? fl[r % 5] : (r == 14 ? 3'b011 : 3'b111);
      a = $urandom;
      m = int'($urandom % 4);
      if (m == 0) a = a & ~32'hFC0;
      else if (m == 1) a = a | 32'hFC0;
      req_addr = a;
      req_wdata = $urandom;
    end
    #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    clear_mems();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_we = 1'b0;
      req_funct3 = 3'b010;
      req_addr = 32'(i * 4);
      @(posedge clk);
      #1;
    end
    req_we = 1'b1;
    req_addr = 32'h16;
    req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1;
    chk("split_ready_low", 32'(req_ready), 0);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_now_ready", 32'(req_ready), 1);
    chk("rst_now_enable", 32'(bram_enable), 0);
    chk("rst_now_valid", 32'(rsp_valid), 0);
    chk("rst_now_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("half_store_word5", mem[5], 32'hBABE0000);
    chk("half_store_word6", mem[6], 32'h0);
    clear_mems();
    single(1'b1, 3'b001, 32'h2, 32'h00001234, 1'b1, 4'b1100, 32'h12340000, 32'h0, 1'b0, 2, "post_sh");
    single(1'b0, 3'b001, 32'h2, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00001234, 1'b0, 2, "post_lh");
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
